// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART-to-cipher block scheduler: byte width,
// default block size and the scheduler FSM state encodings.
package uart_ctrl_pkg;

  localparam int BYTE_W        = 8;
  localparam int DEF_BLK_BYTES = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/blk_byte_shifter.sv
// Byte-wide block shift register: serial-in for packing, parallel-load plus
// serial-out (MSB byte first) for unpacking, with a count of bytes moved.
module blk_byte_shifter
  import uart_ctrl_pkg::*;
#(
  parameter int BLK_BYTES = DEF_BLK_BYTES,
  parameter int CNT_BITS  = $clog2(BLK_BYTES + 1)
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        clr,
  input  logic                        shift_in,
  input  logic [BYTE_W-1:0]           byte_in,
  input  logic                        load,
  input  logic [BYTE_W*BLK_BYTES-1:0] load_data,
  input  logic                        shift_out,
  output logic [BYTE_W*BLK_BYTES-1:0] data,
  output logic [BYTE_W-1:0]           top_byte,
  output logic [CNT_BITS-1:0]         count
);

  localparam int W = BYTE_W * BLK_BYTES;

  // New bytes enter at the LSB end so the first byte ends up in the MSBs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      data  <= '0;
      count <= '0;
    end else if (load) begin
      data  <= load_data;
      count <= '0;
    end else if (shift_in) begin
      data  <= {data[W-BYTE_W-1:0], byte_in};
      count <= count + CNT_BITS'(1);
    end else if (shift_out) begin
      data  <= {data[W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      count <= count + CNT_BITS'(1);
    end else if (clr) begin
      count <= '0;
    end
  end

  assign top_byte = data[W-1 -: BYTE_W];

endmodule

// File: rtl/uart_block_sched.sv
// Moves one cipher block at a time from the UART receive FIFO through the
// block cipher core and back out into the UART send FIFO.
module uart_block_sched
  import uart_ctrl_pkg::*;
#(
  parameter int BLK_BYTES = DEF_BLK_BYTES,
  parameter int CNT_W     = 6,
  parameter int SND_DEPTH = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic                        In_enable,
  input  logic                        In_rcv_empty,
  output logic                        Out_rcv_rd_en,
  input  logic [BYTE_W-1:0]           In_rcv_dout,
  input  logic                        In_snd_full,
  input  logic [CNT_W-1:0]            In_snd_wr_data_count,
  output logic                        Out_snd_wr_en,
  output logic [BYTE_W-1:0]           Out_snd_din,
  output logic                        Out_core_start,
  output logic [BYTE_W*BLK_BYTES-1:0] Out_core_din,
  input  logic                        In_core_done,
  input  logic [BYTE_W*BLK_BYTES-1:0] In_core_dout,
  output logic                        Out_comp_done,
  output logic                        Out_busy,
  output logic                        Out_err
);

  localparam int BW = $clog2(BLK_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0]  BLK_N    = BW'(BLK_BYTES);
  localparam logic [BW-1:0]  BLK_LAST = BW'(BLK_BYTES - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNT_W:0] ROOM     = (CNT_W + 1)'(SND_DEPTH - BLK_BYTES);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [BW-1:0] rd_cnt;
  logic [BW-1:0] pk_cnt;
  logic [BW-1:0] up_cnt;
  logic [TW-1:0] wait_cnt;
  logic          cap_pend;
  logic          rd_fire;
  logic          wr_fire;
  logic          last_cap;
  logic          last_wr;
  logic          core_hit;
  logic          timeout_hit;
  logic          room_ok;

  logic [BYTE_W-1:0]           pk_byte_unused;
  logic [BYTE_W*BLK_BYTES-1:0] up_block_unused;

  // FIFO strobes are qualified by the live flags so a read never hits an
  // empty FIFO and a write never hits a full one, even back-to-back.
  assign rd_fire       = (state == ST_LOAD) && !In_rcv_empty && (rd_cnt < BLK_N);
  assign wr_fire       = (state == ST_STORE) && !In_snd_full;
  assign Out_rcv_rd_en = rd_fire;
  assign Out_snd_wr_en = wr_fire;

  assign room_ok     = {1'b0, In_snd_wr_data_count} <= ROOM;
  assign last_cap    = cap_pend && (pk_cnt == BLK_LAST);
  assign last_wr     = wr_fire && (up_cnt == BLK_LAST);
  assign core_hit    = (state == ST_WAIT) && In_core_done;
  assign timeout_hit = (state == ST_WAIT) && !In_core_done && (wait_cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (In_enable && !In_rcv_empty && room_ok) state_nxt = ST_LOAD;
      ST_LOAD:  if (last_cap) state_nxt = ST_START;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (core_hit)         state_nxt = ST_STORE;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_STORE: if (last_wr) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pulse/level outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state          <= ST_IDLE;
      rd_cnt         <= '0;
      cap_pend       <= 1'b0;
      wait_cnt       <= '0;
      Out_err        <= 1'b0;
      Out_core_start <= 1'b0;
      Out_comp_done  <= 1'b0;
      Out_busy       <= 1'b0;
    end else begin
      state    <= state_nxt;
      cap_pend <= rd_fire;
      if (state == ST_IDLE)  rd_cnt <= '0;
      else if (rd_fire)      rd_cnt <= rd_cnt + BW'(1);
      if (state == ST_WAIT)  wait_cnt <= wait_cnt + TW'(1);
      else                   wait_cnt <= '0;
      if (timeout_hit)       Out_err <= 1'b1;
      Out_core_start <= (state_nxt == ST_START);
      Out_comp_done  <= (state_nxt == ST_DONE);
      Out_busy       <= (state_nxt != ST_IDLE);
    end
  end

  blk_byte_shifter #(.BLK_BYTES(BLK_BYTES), .CNT_BITS(BW)) u_packer (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .clr       (state == ST_IDLE),
    .shift_in  (cap_pend),
    .byte_in   (In_rcv_dout),
    .load      (1'b0),
    .load_data ('0),
    .shift_out (1'b0),
    .data      (Out_core_din),
    .top_byte  (pk_byte_unused),
    .count     (pk_cnt)
  );

  blk_byte_shifter #(.BLK_BYTES(BLK_BYTES), .CNT_BITS(BW)) u_unpacker (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .clr       (1'b0),
    .shift_in  (1'b0),
    .byte_in   ('0),
    .load      (core_hit),
    .load_data (In_core_dout),
    .shift_out (wr_fire),
    .data      (up_block_unused),
    .top_byte  (Out_snd_din),
    .count     (up_cnt)
  );

endmodule

// File: tb/tb_uart_block_sched.sv
// Randomized scoreboard bench for uart_block_sched: FIFO and core models feed
// the DUT, expected core blocks and send bytes are queued at stimulus time.
module tb_uart_block_sched;

  localparam int BLK = 16;
  localparam int TO  = 64;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b1;
  logic         In_enable = 1'b0;
  logic         rcv_empty = 1'b1;
  logic [7:0]   rcv_dout = 8'h00;
  logic         bp_force = 1'b0;
  logic         rand_full = 1'b0;
  logic         rand_bp = 1'b0;
  logic [5:0]   snd_cnt = 6'd0;
  logic         model_done = 1'b0;
  logic         spur_done = 1'b0;
  logic [127:0] core_dout = '0;
  logic         rand_lat = 1'b0;
  int           core_lat = 10;

  logic         rd_en, wr_en, core_start, comp_done, busy, err;
  logic [7:0]   snd_din;
  logic [127:0] core_din;
  logic         snd_full;
  logic         core_done;

  assign snd_full  = bp_force | rand_full;
  assign core_done = model_done | spur_done;

  logic [7:0]   rcv_q[$];
  logic [7:0]   exp_snd_q[$];
  logic [127:0] exp_blk_q[$];
  bit           respond_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cnt = 0, done_cnt = 0, wr_cnt = 0, rd_strobes = 0;
  int last_start_cyc = 0, err_cyc = 0;
  bit err_seen = 1'b0;

  uart_block_sched #(.BLK_BYTES(BLK), .CNT_W(6), .SND_DEPTH(64), .TIMEOUT(TO)) dut (
    .Clk                  (Clk),
    .Rst_n                (Rst_n),
    .In_enable            (In_enable),
    .In_rcv_empty         (rcv_empty),
    .Out_rcv_rd_en        (rd_en),
    .In_rcv_dout          (rcv_dout),
    .In_snd_full          (snd_full),
    .In_snd_wr_data_count (snd_cnt),
    .Out_snd_wr_en        (wr_en),
    .Out_snd_din          (snd_din),
    .Out_core_start       (core_start),
    .Out_core_din         (core_din),
    .In_core_done         (core_done),
    .In_core_dout         (core_dout),
    .Out_comp_done        (comp_done),
    .Out_busy             (busy),
    .Out_err              (err)
  );

  initial forever #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Registers the expected core input and send bytes, then loads the first n bytes.
  task automatic applyStimulus(input logic [127:0] blk, input bit respond, input int n);
    exp_blk_q.push_back(blk);
    respond_q.push_back(respond);
    if (respond)
      for (int i = 0; i < BLK; i++) exp_snd_q.push_back(blk[127-8*i -: 8] ^ 8'hFF);
    for (int i = 0; i < n; i++) rcv_q.push_back(blk[127-8*i -: 8]);
    rcv_empty = (rcv_q.size() == 0);
  endtask

  task automatic feedBytes(input logic [127:0] blk, input int lo);
    for (int i = lo; i < BLK; i++) rcv_q.push_back(blk[127-8*i -: 8]);
    rcv_empty = (rcv_q.size() == 0);
  endtask

  task automatic randBlock(output logic [127:0] blk);
    for (int i = 0; i < BLK; i++) blk[127-8*i -: 8] = 8'($urandom);
  endtask

  task automatic waitDone(input string name, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge Clk);
    checkCount({name, "_completed"}, (done_cnt >= target) ? 1 : 0, 1);
    @(posedge Clk); #1;
  endtask

  task automatic resetPulse(input string name);
    Rst_n = 1'b0;
    #1;
    checkOutput({name, "_ctrl_zero"}, 128'({rd_en, wr_en, snd_din, core_start, comp_done, busy, err}), '0);
    checkOutput({name, "_core_din_zero"}, core_din, '0);
    rcv_q.delete(); exp_snd_q.delete(); exp_blk_q.delete(); respond_q.delete();
    rcv_empty = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      checkOutput({name, "_hold_strobes"}, 128'({rd_en, wr_en}), '0);
    end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
  endtask

  // Receive FIFO model: a strobe seen mid-cycle pops at the following edge.
  initial begin
    logic rd;
    forever begin
      @(negedge Clk);
      rd = rd_en;
      @(posedge Clk); #1;
      if (rd && rcv_q.size() > 0) rcv_dout = rcv_q.pop_front();
      rcv_empty = (rcv_q.size() == 0);
    end
  end

  initial forever begin
    @(posedge Clk); #1;
    rand_full = rand_bp && ($urandom_range(0, 3) == 0);
  end

  // Core model: checks the packed block, answers with the block XOR 0xFF.
  initial begin
    logic [127:0] blk, res;
    bit           resp;
    int           lat;
    forever begin
      @(negedge Clk);
      if (Rst_n && core_start) begin
        vectors++;
        if (exp_blk_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL core_start_unexpected: got start, expected none");
        end else begin
          blk  = exp_blk_q.pop_front();
          resp = respond_q.pop_front();
          vectors--;
          checkOutput("core_din", core_din, blk);
          if (resp) begin
            res = core_din ^ {16{8'hFF}};
            lat = rand_lat ? int'($urandom_range(1, 40)) : core_lat;
            repeat (lat) @(posedge Clk);
            #1; core_dout = res; model_done = 1'b1;
            @(posedge Clk); #1; model_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: scoreboard pop on every send write plus FIFO protocol checks.
  initial begin
    logic [7:0] exp;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Rst_n) begin
        err_seen = 1'b0;
      end else begin
        if (rd_en) begin
          rd_strobes++;
          checkOutput("rd_en_while_empty", 128'(rcv_empty), '0);
        end
        if (wr_en) begin
          wr_cnt++;
          checkOutput("wr_en_while_full", 128'(snd_full), '0);
          if (exp_snd_q.size() == 0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL snd_unexpected_write: got %0h, expected no write", snd_din);
          end else begin
            exp = exp_snd_q.pop_front();
            checkOutput("snd_din", 128'(snd_din), 128'(exp));
          end
        end
        if (core_start) begin start_cnt++; last_start_cyc = cyc; end
        if (comp_done) done_cnt++;
        if (err && !err_seen) begin err_seen = 1'b1; err_cyc = cyc; end
      end
    end
  end

  initial begin
    logic [127:0] blk;
    logic [7:0]   head;
    int s0, d0, w0, r0;

    #2 Rst_n = 1'b0;
    repeat (3) @(posedge Clk); #1;
    checkOutput("reset_ctrl_zero", 128'({rd_en, wr_en, snd_din, core_start, comp_done, busy, err}), '0);
    checkOutput("reset_core_din_zero", core_din, '0);
    Rst_n = 1'b1;
    @(posedge Clk); #1;

    $display("[TB] nominal block 00..0F");
    for (int i = 0; i < BLK; i++) blk[127-8*i -: 8] = 8'(i);
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt;
    applyStimulus(blk, 1'b1, BLK);
    In_enable = 1'b1;
    waitDone("nominal", d0 + 1, 300);
    checkCount("nominal_starts", start_cnt - s0, 1);
    checkCount("nominal_writes", wr_cnt - w0, BLK);
    checkCount("nominal_comp_done", done_cnt - d0, 1);

    $display("[TB] receive underflow");
    randBlock(blk);
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt; r0 = rd_strobes;
    applyStimulus(blk, 1'b1, 5);
    repeat (20) @(negedge Clk);
    checkCount("underflow_stall_reads", rd_strobes - r0, 5);
    checkCount("underflow_stall_starts", start_cnt - s0, 0);
    checkOutput("underflow_stall_busy", 128'(busy), 128'(1));
    @(posedge Clk); #1;
    feedBytes(blk, 5);
    waitDone("underflow", d0 + 1, 300);
    checkCount("underflow_starts", start_cnt - s0, 1);
    checkCount("underflow_writes", wr_cnt - w0, BLK);

    $display("[TB] send backpressure");
    randBlock(blk);
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt;
    applyStimulus(blk, 1'b1, BLK);
    for (int i = 0; i < 300 && (wr_cnt - w0) < 3; i++) begin @(posedge Clk); #1; end
    checkCount("bp_third_write_seen", wr_cnt - w0, 3);
    bp_force = 1'b1;
    repeat (8) begin
      @(negedge Clk);
      head = exp_snd_q[0];
      checkOutput("bp_wr_en_low", 128'(wr_en), '0);
      checkOutput("bp_din_held", 128'(snd_din), 128'(head));
    end
    @(posedge Clk); #1;
    bp_force = 1'b0;
    waitDone("backpressure", d0 + 1, 300);
    checkCount("bp_writes", wr_cnt - w0, BLK);
    checkCount("bp_starts", start_cnt - s0, 1);

    $display("[TB] core timeout");
    randBlock(blk);
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt;
    applyStimulus(blk, 1'b0, BLK);
    for (int i = 0; i < 400 && !err_seen; i++) @(negedge Clk);
    @(negedge Clk);
    checkCount("timeout_err_seen", err_seen ? 1 : 0, 1);
    checkCount("timeout_cycles", err_cyc - last_start_cyc, TO + 1);
    checkOutput("timeout_idle", 128'(busy), '0);
    repeat (10) @(negedge Clk);
    checkOutput("timeout_err_sticky", 128'(err), 128'(1));
    checkCount("timeout_writes", wr_cnt - w0, 0);
    checkCount("timeout_comp_done", done_cnt - d0, 0);
    checkCount("timeout_starts", start_cnt - s0, 1);
    @(posedge Clk); #1;
    resetPulse("timeout_reset");
    @(negedge Clk);
    checkOutput("err_cleared_by_reset", 128'(err), '0);
    @(posedge Clk); #1;

    $display("[TB] reset during load");
    randBlock(blk);
    r0 = rd_strobes;
    applyStimulus(blk, 1'b1, BLK);
    for (int i = 0; i < 300 && (rd_strobes - r0) < 7; i++) begin @(posedge Clk); #1; end
    checkCount("midload_reads", rd_strobes - r0, 7);
    resetPulse("midload_reset");
    randBlock(blk);
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt;
    applyStimulus(blk, 1'b1, BLK);
    waitDone("after_reset", d0 + 1, 300);
    checkCount("after_reset_starts", start_cnt - s0, 1);
    checkCount("after_reset_writes", wr_cnt - w0, BLK);

    $display("[TB] no room plus spurious core done");
    snd_cnt = 6'd49;
    randBlock(blk);
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt; r0 = rd_strobes;
    applyStimulus(blk, 1'b1, BLK);
    repeat (30) begin @(posedge Clk); #1; spur_done = ~spur_done; end
    spur_done = 1'b0;
    @(negedge Clk);
    checkOutput("noroom_idle", 128'(busy), '0);
    checkCount("noroom_reads", rd_strobes - r0, 0);
    checkCount("noroom_starts", start_cnt - s0, 0);
    @(posedge Clk); #1;
    snd_cnt = 6'd48;
    repeat (10) begin @(posedge Clk); #1; spur_done = ~spur_done; end
    spur_done = 1'b0;
    waitDone("room_boundary", d0 + 1, 300);
    checkCount("room_boundary_starts", start_cnt - s0, 1);
    checkCount("room_boundary_writes", wr_cnt - w0, BLK);
    snd_cnt = 6'd0;

    $display("[TB] random blocks with backpressure and enable drop");
    rand_bp = 1'b1; rand_lat = 1'b1;
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt;
    for (int b = 0; b < 6; b++) begin
      randBlock(blk);
      applyStimulus(blk, 1'b1, BLK);
    end
    for (int i = 0; i < 300 && start_cnt == s0; i++) begin @(posedge Clk); #1; end
    In_enable = 1'b0;
    waitDone("random_first", d0 + 1, 400);
    repeat (5) @(negedge Clk);
    checkCount("enable_low_starts", start_cnt - s0, 1);
    @(posedge Clk); #1;
    In_enable = 1'b1;
    waitDone("random_all", d0 + 6, 3000);
    checkCount("random_starts", start_cnt - s0, 6);
    checkCount("random_writes", wr_cnt - w0, 6 * BLK);
    checkCount("scoreboard_drained", exp_snd_q.size(), 0);
    rand_bp = 1'b0; rand_lat = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
